upsampler_nx_stream: RTL and testbench

//  Single-clock pixel-replication upsampler, generalised successor to the fixed 4x upsampler.
//  - Accepts a raster stream of SRC_COLS x SRC_ROWS pixels.
//  - Emits each pixel 2^SCALE_LOG2 times horizontally and each row 2^SCALE_LOG2 times vertically.
//  - Emits output row/column coordinates with every beat.
//  - Sits after a clock-crossing FIFO, in front of the feature-detection pipeline; ready/valid on both sides.

---
 rtl/upsampler_nx_stream.sv | 183 ++++++++++++++++++
 tb/tb_upsampler_nx_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsampler_nx_stream.sv
// Pixel-replication upsampler: every source pixel becomes a 2^SCALE_LOG2 x 2^SCALE_LOG2 block.
// Optional feature macro UPS_PINGPONG_EN selects a double line buffer so filling overlaps replay.
module upsampler_nx_stream #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SRC_COLS   = 160,
    parameter int unsigned SRC_ROWS   = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned ROW_W      = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_rownum,
    output logic [COL_W-1:0]  out_colnum,
    output logic              frame_done
);
    localparam int unsigned S     = 1 << SCALE_LOG2;
    localparam int unsigned PTR_W = (SRC_COLS > 1) ? $clog2(SRC_COLS) : 1;
    localparam int unsigned SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
`ifdef UPS_PINGPONG_EN
    localparam int unsigned NBUF  = 2;
`else
    localparam int unsigned NBUF  = 1;
`endif
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SRC_COLS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_COLS * S - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_ROWS * S - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(S - 1);

    typedef enum logic [1:0] {StFill, StReplay, StDrain} state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_buf [NBUF][SRC_COLS];
    logic [NBUF-1:0]   r_full;
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic              r_in_ready;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [COL_W-1:0]  r_iss_col;
    logic [SUB_W-1:0]  r_iss_sub;
    logic [ROW_W-1:0]  r_row_base;
    logic              r_rd_vld, r_rd_eor, r_rd_eof;
    logic [DATA_W-1:0] r_rd_data;
    logic [COL_W-1:0]  r_rd_col;
    logic [ROW_W-1:0]  r_rd_row;
    logic              r_out_valid, r_out_eor, r_out_eof, r_frame_done;
    logic [DATA_W-1:0] r_out_data;
    logic [COL_W-1:0]  r_out_col;
    logic [ROW_W-1:0]  r_out_row;

    logic              w_in_xfer, w_out_xfer, w_out_adv, w_rd_adv, w_issue, w_iss_eor;
    logic [ROW_W-1:0]  w_iss_row, w_row_top;
    logic [PTR_W-1:0]  w_rd_addr;
    logic [NBUF-1:0]   w_full_d;
    logic              w_wr_sel_d;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    // Two-stage pipeline (RAM read, output register) that stalls from the output backwards.
    assign w_out_adv  = ~r_out_valid | out_ready;
    assign w_rd_adv   = ~r_rd_vld | w_out_adv;
    assign w_issue    = (r_state == StReplay) & w_rd_adv;
    assign w_iss_eor  = (r_iss_col == COL_LAST) & (r_iss_sub == SUB_LAST);
    assign w_iss_row  = r_row_base + ROW_W'(r_iss_sub);
    assign w_row_top  = r_row_base + ROW_W'(S - 1);
    assign w_rd_addr  = PTR_W'(r_iss_col >> SCALE_LOG2);

    always_comb begin
        w_full_d   = r_full;
        w_wr_sel_d = r_wr_sel;
        if (w_in_xfer && r_wr_ptr == PTR_LAST) begin
            w_full_d[r_wr_sel] = 1'b1;
`ifdef UPS_PINGPONG_EN
            w_wr_sel_d = ~r_wr_sel;
`endif
        end
`ifdef UPS_PINGPONG_EN
        // The last read of a row happens at issue, so its buffer can refill immediately.
        if (w_issue && w_iss_eor) w_full_d[r_rd_sel] = 1'b0;
`else
        if (w_out_xfer && r_out_eor) w_full_d[r_rd_sel] = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (w_in_xfer) r_buf[r_wr_sel][r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StFill;
            r_full       <= '0;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_in_ready   <= 1'b0;
            r_wr_ptr     <= '0;
            r_iss_col    <= '0;
            r_iss_sub    <= '0;
            r_row_base   <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_eor     <= 1'b0;
            r_rd_eof     <= 1'b0;
            r_rd_data    <= '0;
            r_rd_col     <= '0;
            r_rd_row     <= '0;
            r_out_valid  <= 1'b0;
            r_out_eor    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_out_data   <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_full     <= w_full_d;
            r_wr_sel   <= w_wr_sel_d;
            r_in_ready <= ~w_full_d[w_wr_sel_d];
            if (w_in_xfer) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;

            unique case (r_state)
                StFill: if (w_full_d[r_rd_sel]) r_state <= StReplay;
                StReplay: begin
                    if (w_issue && w_iss_eor) begin
`ifdef UPS_PINGPONG_EN
                        r_rd_sel <= ~r_rd_sel;
                        r_state  <= w_full_d[~r_rd_sel] ? StReplay : StFill;
`else
                        r_state  <= StDrain;
`endif
                    end
                end
                StDrain: if (w_out_xfer && r_out_eor) r_state <= StFill;
                default: r_state <= StFill;
            endcase

            if (w_issue) begin
                if (r_iss_col == COL_LAST) begin
                    r_iss_col <= '0;
                    r_iss_sub <= (r_iss_sub == SUB_LAST) ? '0 : r_iss_sub + 1'b1;
                end else begin
                    r_iss_col <= r_iss_col + 1'b1;
                end
                if (w_iss_eor) r_row_base <= (w_row_top == ROW_LAST) ? '0 : r_row_base + ROW_W'(S);
            end

            if (w_rd_adv) begin
                r_rd_vld <= w_issue;
                if (w_issue) begin
                    r_rd_data <= r_buf[r_rd_sel][w_rd_addr];
                    r_rd_col  <= r_iss_col;
                    r_rd_row  <= w_iss_row;
                    r_rd_eor  <= w_iss_eor;
                    r_rd_eof  <= w_iss_eor && (w_iss_row == ROW_LAST);
                end
            end

            if (w_out_adv) begin
                r_out_valid <= r_rd_vld;
                if (r_rd_vld) begin
                    r_out_data <= r_rd_data;
                    r_out_col  <= r_rd_col;
                    r_out_row  <= r_rd_row;
                    r_out_eor  <= r_rd_eor;
                    r_out_eof  <= r_rd_eof;
                end
            end

            r_frame_done <= w_out_xfer & r_out_eof;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_rownum = r_out_row;
    assign out_colnum = r_out_col;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_upsampler_nx_stream.sv
// Bench for upsampler_nx_stream with a 4x2 source and 2x scale; expected beats are queued per row.
module tb_upsampler_nx_stream;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SRC_COLS   = 4;
    localparam int unsigned SRC_ROWS   = 2;
    localparam int unsigned SCALE_LOG2 = 1;
    localparam int unsigned COL_W      = 10;
    localparam int unsigned ROW_W      = 10;
    localparam int unsigned S          = 1 << SCALE_LOG2;
    localparam int unsigned OUT_COLS   = SRC_COLS * S;

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_rownum;
    logic [COL_W-1:0]  out_colnum;
    logic              frame_done;

    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
        bit         eof;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    fd_cnt = 0;
    int    src_row = 0;
    bit    s6_active = 0;
    bit    fd_exp = 0;
    bit    hold_prev = 0;
    bit    gap_chk = 0;
    logic [DATA_W-1:0] hold_data;
    logic [ROW_W-1:0]  hold_row;
    logic [COL_W-1:0]  hold_col;
    beat_t e_mon;

    upsampler_nx_stream #(
        .DATA_W    (DATA_W),
        .SRC_COLS  (SRC_COLS),
        .SRC_ROWS  (SRC_ROWS),
        .SCALE_LOG2(SCALE_LOG2),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rownum(out_rownum),
        .out_colnum(out_colnum),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-while-stalled and frame_done pulse timing.
    always @(negedge clock) begin
        if (frame_done || fd_exp) chk("frame_done", frame_done, fd_exp);
        if (frame_done) fd_cnt++;
        fd_exp = 0;
        if (hold_prev && out_valid && !reset) begin
            chk("hold_data", out_data, hold_data);
            chk("hold_row", out_rownum, hold_row);
            chk("hold_col", out_colnum, hold_col);
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
        hold_row  = out_rownum;
        hold_col  = out_colnum;
`ifdef UPS_PINGPONG_EN
        if (gap_chk) chk("row1_row2_gap", out_valid, 1);
        gap_chk = s6_active && out_valid && out_ready && out_rownum == 1 && out_colnum == 7;
        if (s6_active && out_valid && out_rownum == 0 && out_colnum == 0)
            chk("in_ready_during_replay", in_ready, 1);
`else
        if (s6_active && out_valid) chk("in_ready_during_replay", in_ready, 0);
`endif
        if (out_valid && out_ready && !reset) begin
            if (q.size() == 0) begin
                chk("extra_beat", out_valid, 0);
            end else begin
                e_mon = q.pop_front();
                chk("beat_data", out_data, e_mon.data);
                chk("beat_row", out_rownum, e_mon.row);
                chk("beat_col", out_colnum, e_mon.col);
                fd_exp = e_mon.eof;
            end
        end
    end

    task automatic send_pixel(input logic [7:0] d, input bit gap);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 400);
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        @(posedge clock);
        #1;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_row(input logic [31:0] pix, input bit gap);
        beat_t e;
        for (int i = 0; i < SRC_COLS; i++) send_pixel(pix[31-8*i -: 8], gap);
        in_valid = 1'b0;
        for (int r = 0; r < S; r++) begin
            for (int k = 0; k < OUT_COLS; k++) begin
                e.data = pix[31-8*(k>>SCALE_LOG2) -: 8];
                e.row  = src_row * S + r;
                e.col  = k;
                e.eof  = (src_row == SRC_ROWS - 1) && (r == S - 1) && (k == OUT_COLS - 1);
                q.push_back(e);
            end
        end
        src_row = (src_row + 1) % SRC_ROWS;
    endtask

    task automatic wait_beat(input int row, input int col, input string tag);
        int n   = 0;
        bit hit = 0;
        while (!hit && n < 400) begin
            @(negedge clock);
            n++;
            hit = out_valid && out_ready && out_rownum == row && out_colnum == col;
        end
        chk(tag, hit, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(tag, q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int fd0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rownum", out_rownum, 0);
        chk("rst_colnum", out_colnum, 0);
        chk("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Row 10,20,30,40 with first-beat latency.
        fd0 = fd_cnt;
        send_row(32'h0A141E28, 0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("first_valid_latency", lat, 2);
        drain("drain_s1");

        // Second source row with a 3-cycle stall at colnum 3.
        send_row(32'h0A141E28, 0);
        wait_beat(2, 2, "wait_stall_point");
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_data", out_data, 20);
            chk("stall_col", out_colnum, 3);
            chk("stall_row", out_rownum, 2);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain("drain_s2");
        chk("frame_done_count_f1", fd_cnt - fd0, 1);

        // Full frame 1..4 / 5..8.
        fd0 = fd_cnt;
        send_row(32'h01020304, 0);
        send_row(32'h05060708, 0);
        drain("drain_s3");
        chk("frame_done_count_f2", fd_cnt - fd0, 1);

        // Reset in the middle of replay.
        send_row(32'h01020304, 0);
        wait_beat(1, 1, "wait_rst_point");
        @(posedge clock);
        #1;
        reset     = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        q.delete();
        src_row   = 0;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("in_ready_after_mid_rst", in_ready, 1);
        fd0 = fd_cnt;
        send_row(32'h09090909, 0);
        drain("drain_s4");

        // Toggling in_valid with junk data in the gaps.
        send_row(32'h0A141E28, 1);
        drain("drain_s5");
        chk("frame_done_count_f3", fd_cnt - fd0, 1);

        // Continuous input.
        s6_active = 1'b1;
        send_row(32'h11223344, 0);
        send_row(32'h55667788, 0);
        drain("drain_s6");
        s6_active = 1'b0;

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
